bg_subtract_adaptive: RTL and testbench

Streaming background subtractor for the video pipeline. It pops one pixel per cycle from a background FIFO and a current-image FIFO, both first-word-fall-through, each with CHANNELS x 8-bit lanes. Per pixel it produces an 8-bit foreground mask (0xFF or 0x00) and an adaptively updated background pixel. It also keeps per-frame pixel and foreground counts. It replaces the fixed grayscale/fixed-threshold subtractor.

---
 rtl/bg_subtract_adaptive.sv | 117 +++++++++++
 tb/tb_bg_subtract_adaptive.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_subtract_adaptive.sv
// Streaming adaptive background subtractor: per-pixel foreground mask, running-average
// background update and per-frame foreground count, behind a single output register stage.
module bg_subtract_adaptive #(
  parameter int unsigned WIDTH       = 768,
  parameter int unsigned HEIGHT      = 576,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned MODE        = 0,
  parameter int unsigned ALPHA_SHIFT = 3,
  parameter int unsigned UPDATE_FG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [9:0]            thresh,
  input  logic                  in_empty_base,
  output logic                  in_rd_en_base,
  input  logic [CHANNELS*8-1:0] in_dout_base,
  input  logic                  in_empty_img,
  output logic                  in_rd_en_img,
  input  logic [CHANNELS*8-1:0] in_dout_img,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [7:0]            out_din,
  input  logic                  bg_full,
  output logic                  bg_wr_en,
  output logic [CHANNELS*8-1:0] bg_din,
  output logic                  frame_done,
  output logic [19:0]           fg_count
);

  localparam int unsigned PW   = CHANNELS * 8;
  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic          valid_q;
  logic          fg_q, fg_d;
  logic [PW-1:0] bg_q, bg_d;
  logic [CW-1:0] cnt_q;
  logic [19:0]   acc_q;
  logic [19:0]   fg_count_q;
  logic [9:0]    thresh_q;

  logic          stall, pop, wr, last, frame_end;
  logic [9:0]    thr_eff;
  logic [PW-1:0] upd;
  logic [9:0]    metric;

  assign stall     = valid_q & (out_full | bg_full);
  assign pop       = ~in_empty_base & ~in_empty_img & ~stall & reset;
  // Writes are also gated by reset so an in-flight pixel is dropped, not emitted.
  assign wr        = valid_q & ~out_full & ~bg_full & reset;
  assign last      = (cnt_q == CW'(NPIX - 1));
  assign frame_end = wr & last;
  // A pixel popped while the frame's last pixel is written belongs to the next frame.
  assign thr_eff   = frame_end ? thresh : thresh_q;

  always_comb begin
    logic [7:0]        b_l, i_l, ad, m_max;
    logic [9:0]        m_sum;
    logic signed [8:0] diff, step, sum_s;
    upd   = '0;
    m_max = '0;
    m_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      b_l   = in_dout_base[c*8 +: 8];
      i_l   = in_dout_img[c*8 +: 8];
      diff  = signed'({1'b0, i_l}) - signed'({1'b0, b_l});
      ad    = diff[8] ? 8'(-diff) : diff[7:0];
      step  = diff >>> ALPHA_SHIFT;
      sum_s = signed'({1'b0, b_l}) + step;
      upd[c*8 +: 8] = sum_s[7:0];
      if (ad > m_max) m_max = ad;
      m_sum = m_sum + {2'b00, ad};
    end
    metric = (MODE == 1) ? m_sum : {2'b00, m_max};
    fg_d   = (metric > thr_eff);
    bg_d   = (fg_d && (UPDATE_FG == 0)) ? in_dout_base : upd;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      fg_q       <= 1'b0;
      bg_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      fg_count_q <= '0;
      thresh_q   <= thresh;
    end else begin
      if (!stall) valid_q <= pop;
      if (pop) begin
        fg_q <= fg_d;
        bg_q <= bg_d;
      end
      if (wr) begin
        if (last) begin
          cnt_q      <= '0;
          acc_q      <= '0;
          fg_count_q <= acc_q + 20'(fg_q);
          thresh_q   <= thresh;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_q + 20'(fg_q);
        end
      end
    end
  end

  assign in_rd_en_base = pop;
  assign in_rd_en_img  = pop;
  assign out_wr_en     = wr;
  assign bg_wr_en      = wr;
  assign out_din       = {8{fg_q}};
  assign bg_din        = bg_q;
  assign frame_done    = frame_end;
  assign fg_count      = fg_count_q;

endmodule

// File: tb/tb_bg_subtract_adaptive.sv
// Directed bench: two instances (max and sum metric) share one FIFO model and sink,
// with a 4x2 frame so frame accounting is exercised quickly.
module tb_bg_subtract_adaptive;
  localparam int unsigned PW = 24;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset    = 1'b0;
  logic [9:0] thresh   = 10'd20;
  logic       out_full = 1'b0;
  logic       bg_full  = 1'b0;
  logic       hold_b   = 1'b0;
  logic       hold_i   = 1'b0;

  logic [PW-1:0] bmem [0:255];
  logic [PW-1:0] imem [0:255];
  int b_wr = 0, i_wr = 0, b_rd = 0, i_rd = 0;

  logic          in_empty_base, in_empty_img;
  logic [PW-1:0] in_dout_base, in_dout_img;
  assign in_empty_base = (b_rd == b_wr) || hold_b;
  assign in_empty_img  = (i_rd == i_wr) || hold_i;
  assign in_dout_base  = bmem[b_rd[7:0]];
  assign in_dout_img   = imem[i_rd[7:0]];

  logic          rd_b0, rd_i0, wr0, bgwr0, fd0;
  logic [7:0]    din0;
  logic [PW-1:0] bgdin0;
  logic [19:0]   fgc0;
  logic          rd_b1, rd_i1, wr1, bgwr1, fd1;
  logic [7:0]    din1;
  logic [PW-1:0] bgdin1;
  logic [19:0]   fgc1;

  bg_subtract_adaptive #(
    .WIDTH(4), .HEIGHT(2), .CHANNELS(3), .MODE(0), .ALPHA_SHIFT(3), .UPDATE_FG(0)
  ) dut0 (
    .clock(clock), .reset(reset), .thresh(thresh),
    .in_empty_base(in_empty_base), .in_rd_en_base(rd_b0), .in_dout_base(in_dout_base),
    .in_empty_img(in_empty_img), .in_rd_en_img(rd_i0), .in_dout_img(in_dout_img),
    .out_full(out_full), .out_wr_en(wr0), .out_din(din0),
    .bg_full(bg_full), .bg_wr_en(bgwr0), .bg_din(bgdin0),
    .frame_done(fd0), .fg_count(fgc0)
  );

  bg_subtract_adaptive #(
    .WIDTH(4), .HEIGHT(2), .CHANNELS(3), .MODE(1), .ALPHA_SHIFT(3), .UPDATE_FG(0)
  ) dut1 (
    .clock(clock), .reset(reset), .thresh(thresh),
    .in_empty_base(in_empty_base), .in_rd_en_base(rd_b1), .in_dout_base(in_dout_base),
    .in_empty_img(in_empty_img), .in_rd_en_img(rd_i1), .in_dout_img(in_dout_img),
    .out_full(out_full), .out_wr_en(wr1), .out_din(din1),
    .bg_full(bg_full), .bg_wr_en(bgwr1), .bg_din(bgdin1),
    .frame_done(fd1), .fg_count(fgc1)
  );

  // FIFO pop model and output sink, acting on the transfer edge.
  int n_out = 0, n_out1 = 0, viol = 0, fd_n = 0, fd_idx = -1;
  logic [7:0]    mask_log  [0:255];
  logic [PW-1:0] bg_log    [0:255];
  logic [7:0]    mask1_log [0:255];

  always @(posedge clock) begin
    if (rd_b0) b_rd <= b_rd + 1;
    if (rd_i0) i_rd <= i_rd + 1;
    if (wr0) begin
      mask_log[n_out[7:0]] <= din0;
      bg_log[n_out[7:0]]   <= bgdin0;
      n_out                <= n_out + 1;
    end
    if (wr1) begin
      mask1_log[n_out1[7:0]] <= din1;
      n_out1                 <= n_out1 + 1;
    end
    if (fd0) begin
      fd_n   <= fd_n + 1;
      fd_idx <= n_out;
    end
    if ((wr0 !== bgwr0) || (wr1 !== bgwr1) || (rd_b0 !== rd_i0) || (rd_b1 !== rd_i1) ||
        (rd_b0 !== rd_b1) || (fd0 && !wr0))
      viol <= viol + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic push(input logic [PW-1:0] b, input logic [PW-1:0] i);
    bmem[b_wr[7:0]] = b;
    imem[i_wr[7:0]] = i;
    b_wr = b_wr + 1;
    i_wr = i_wr + 1;
  endtask

  task automatic wait_out(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (n_out >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input logic [9:0] thr);
    @(negedge clock);
    reset  = 1'b0;
    thresh = thr;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    push(24'h101010, 24'h104010);
    #1;
    checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr0); end
    checks++; if (din0 !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", din0); end
    checks++; if (bgdin0 !== 24'h0) begin errors++; $display("FAIL reset_bg: got %h want 0", bgdin0); end
    checks++; if (fgc0 !== 20'd0) begin errors++; $display("FAIL reset_fgc: got %0d want 0", fgc0); end
    checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", fd0); end
    checks++; if (rd_b0 !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", rd_b0); end
  endtask

  task automatic test_single_pixel();
    reset = 1'b1;
    #1;
    checks++; if (rd_b0 !== 1'b1) begin errors++; $display("FAIL single_pop: got %b want 1", rd_b0); end
    @(negedge clock); #1;
    checks++; if (wr0 !== 1'b1 || bgwr0 !== 1'b1) begin
      errors++; $display("FAIL single_wr: got %b/%b want 1/1", wr0, bgwr0);
    end
    checks++; if (din0 !== 8'hFF) begin errors++; $display("FAIL single_mask: got %h want ff", din0); end
    checks++; if (bgdin0 !== 24'h101010) begin
      errors++; $display("FAIL single_bg: got %h want 101010", bgdin0);
    end
    @(negedge clock); #1;
    checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL single_once: got %b want 0", wr0); end
  endtask

  task automatic test_threshold();
    int start;
    bit ok;
    logic [7:0]    em [3];
    logic [PW-1:0] eb [3];
    em = '{8'h00, 8'h00, 8'h00};
    eb = '{24'h121010, 24'h121010, 24'h100E10};
    do_reset(10'd20);
    start = n_out;
    push(24'h101010, 24'h201010);  // d=16
    push(24'h101010, 24'h241010);  // d=20, equal to threshold
    push(24'h101010, 24'h100010);  // d=-16 on lane 1
    wait_out(start + 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL thr_timeout: got %0d want %0d", n_out, start + 3); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (mask_log[8'(start + k)] !== em[k]) begin
        errors++; $display("FAIL thr_mask%0d: got %h want %h", k, mask_log[8'(start + k)], em[k]);
      end
      checks++; if (bg_log[8'(start + k)] !== eb[k]) begin
        errors++; $display("FAIL thr_bg%0d: got %h want %h", k, bg_log[8'(start + k)], eb[k]);
      end
    end
  endtask

  task automatic test_mode1();
    int start, start1;
    bit ok;
    logic [7:0]    em0 [3];
    logic [7:0]    em1 [3];
    logic [PW-1:0] eb  [3];
    em0 = '{8'h00, 8'h00, 8'h00};
    em1 = '{8'hFF, 8'hFF, 8'h00};
    eb  = '{24'h111111, 24'h1E2E12, 24'h121111};
    do_reset(10'd40);
    start  = n_out;
    start1 = n_out1;
    push(24'h101010, 24'h1F1F1F);  // 15/15/15: sum 45, max 15
    push(24'h203010, 24'h102020);  // +16/-16/-16: sum 48
    push(24'h101010, 24'h241A1A);  // 10/10/20: sum exactly 40
    wait_out(start + 3, ok);
    repeat (2) @(negedge clock);
    checks++; if (!ok || n_out1 != start1 + 3) begin
      errors++; $display("FAIL m1_timeout: got %0d/%0d want 3 each", n_out - start, n_out1 - start1);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (mask_log[8'(start + k)] !== em0[k]) begin
        errors++; $display("FAIL m0_mask%0d: got %h want %h", k, mask_log[8'(start + k)], em0[k]);
      end
      checks++; if (mask1_log[8'(start1 + k)] !== em1[k]) begin
        errors++; $display("FAIL m1_mask%0d: got %h want %h", k, mask1_log[8'(start1 + k)], em1[k]);
      end
      checks++; if (bg_log[8'(start + k)] !== eb[k]) begin
        errors++; $display("FAIL m0_bg%0d: got %h want %h", k, bg_log[8'(start + k)], eb[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int start, pops, writes;
    bit ok;
    logic [7:0]    em [8];
    logic [PW-1:0] eb [8];
    em = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    eb = '{24'h101010, 24'h101011, 24'h101012, 24'h101010,
           24'h101010, 24'h101010, 24'h101010, 24'h101010};
    do_reset(10'd20);
    start = n_out;
    for (int k = 0; k < 8; k++) push(24'h101010, 24'h101010 + PW'(k * 8));
    repeat (3) @(negedge clock);
    out_full = 1'b1;
    pops     = 0;
    writes   = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (rd_b0) pops++;
      if (wr0) writes++;
      @(negedge clock);
    end
    out_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bg_full = (k[0] == 1'b0);
      @(negedge clock);
    end
    bg_full = 1'b0;
    wait_out(start + 8, ok);
    repeat (3) @(negedge clock);
    checks++; if (pops != 0) begin errors++; $display("FAIL bp_pops: got %0d want 0", pops); end
    checks++; if (writes != 0) begin errors++; $display("FAIL bp_writes: got %0d want 0", writes); end
    checks++; if (!ok || n_out != start + 8) begin
      errors++; $display("FAIL bp_count: got %0d want 8", n_out - start);
    end
    checks++; if (b_rd != b_wr) begin errors++; $display("FAIL bp_drain: got %0d want %0d", b_rd, b_wr); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (mask_log[8'(start + k)] !== em[k] || bg_log[8'(start + k)] !== eb[k]) begin
        errors++;
        $display("FAIL bp_pix%0d: got %h/%h want %h/%h", k, mask_log[8'(start + k)],
                 bg_log[8'(start + k)], em[k], eb[k]);
      end
    end
  endtask

  task automatic test_empty_mismatch();
    int start, pops;
    bit ok;
    do_reset(10'd20);
    hold_i = 1'b1;
    push(24'h101010, 24'h101010);
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rd_b0) pops++;
      @(negedge clock);
    end
    checks++; if (pops != 0) begin errors++; $display("FAIL em_pops: got %0d want 0", pops); end
    checks++; if (b_rd != b_wr - 1 || i_rd != i_wr - 1) begin
      errors++; $display("FAIL em_consumed: got rd %0d/%0d want %0d/%0d", b_rd, i_rd, b_wr - 1, i_wr - 1);
    end
    hold_i = 1'b0;
    start  = n_out;
    for (int k = 0; k < 6; k++) push(24'h101010, k[0] ? 24'h101010 : 24'h104010);
    for (int k = 0; k < 40; k++) begin
      hold_b = 1'($urandom_range(0, 1));
      hold_i = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    hold_b = 1'b0;
    hold_i = 1'b0;
    wait_out(start + 7, ok);
    repeat (2) @(negedge clock);
    checks++; if (!ok || n_out != start + 7) begin
      errors++; $display("FAIL em_count: got %0d want 7", n_out - start);
    end
    checks++; if (b_rd != i_rd || b_rd != b_wr) begin
      errors++; $display("FAIL em_paired: got rd %0d/%0d want %0d", b_rd, i_rd, b_wr);
    end
    for (int k = 0; k < 6; k++) begin
      checks++; if (mask_log[8'(start + 1 + k)] !== (k[0] ? 8'h00 : 8'hFF)) begin
        errors++; $display("FAIL em_order%0d: got %h", k, mask_log[8'(start + 1 + k)]);
      end
    end
  endtask

  task automatic test_frame();
    int start, start3, fdn;
    bit ok;
    logic [7:0] em;
    do_reset(10'd20);
    start = n_out;
    fdn   = fd_n;
    for (int k = 0; k < 13; k++)
      push(24'h101010, (k == 1 || k == 4 || k == 6 || k == 8) ? 24'h104010 :
                       ((k == 9) ? 24'h101050 : 24'h101010));
    repeat (2) @(negedge clock);
    thresh = 10'd50;
    wait_out(start + 13, ok);
    repeat (2) @(negedge clock);
    checks++; if (!ok) begin errors++; $display("FAIL fr_timeout: got %0d want 13", n_out - start); end
    for (int k = 0; k < 13; k++) begin
      em = (k == 1 || k == 4 || k == 6 || k == 9) ? 8'hFF : 8'h00;
      checks++; if (mask_log[8'(start + k)] !== em) begin
        errors++; $display("FAIL fr_mask%0d: got %h want %h", k, mask_log[8'(start + k)], em);
      end
    end
    checks++; if (bg_log[8'(start + 8)] !== 24'h101610) begin
      errors++; $display("FAIL fr_bg8: got %h want 101610", bg_log[8'(start + 8)]);
    end
    checks++; if (fd_n != fdn + 1 || fd_idx != start + 7) begin
      errors++; $display("FAIL fr_done: got %0d pulses at %0d want 1 at %0d", fd_n - fdn, fd_idx, start + 7);
    end
    checks++; if (fgc0 !== 20'd3) begin errors++; $display("FAIL fr_fgc: got %0d want 3", fgc0); end
    // Reset lands while frame-2 pixel 5 is waiting in the output register.
    thresh = 10'd20;
    push(24'h101010, 24'h104010);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL fr_discard: got %b want 0", wr0); end
    @(negedge clock); #1;
    checks++; if (wr0 !== 1'b0 || din0 !== 8'h00 || bgdin0 !== 24'h0 || fd0 !== 1'b0) begin
      errors++; $display("FAIL fr_rst_out: got wr %b din %h bg %h fd %b want all 0", wr0, din0, bgdin0, fd0);
    end
    checks++; if (fgc0 !== 20'd0) begin errors++; $display("FAIL fr_rst_fgc: got %0d want 0", fgc0); end
    checks++; if (n_out != start + 13) begin
      errors++; $display("FAIL fr_rst_count: got %0d want 13", n_out - start);
    end
    reset  = 1'b1;
    start3 = n_out;
    fdn    = fd_n;
    for (int k = 0; k < 8; k++)
      push(24'h101010, (k == 2 || k == 7) ? 24'h104010 : 24'h101010);
    wait_out(start3 + 8, ok);
    repeat (2) @(negedge clock);
    checks++; if (!ok || fd_n != fdn + 1 || fd_idx != start3 + 7) begin
      errors++; $display("FAIL fr3_done: got %0d pulses at %0d want 1 at %0d", fd_n - fdn, fd_idx, start3 + 7);
    end
    checks++; if (fgc0 !== 20'd2) begin errors++; $display("FAIL fr3_fgc: got %0d want 2", fgc0); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_threshold();
    test_mode1();
    test_backpressure();
    test_empty_mismatch();
    test_frame();
    checks++; if (viol != 0) begin errors++; $display("FAIL pairing: got %0d violations want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
